ring_decoder_checker: RTL and testbench

//  Receive-side companion to the one-hot ring counter. Samples a WIDTH-bit ring code, decodes it
//  to a binary index, checks code legality (exactly one bit set), and checks sequence order
//  (each code = previous rotated left by one, MSB wraps to LSB). A HUNT/VERIFY/LOCK FSM reports

---
 rtl/ring_decoder_checker.sv | 125 ++++++++++++
 tb/tb_ring_decoder_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ring_decoder_checker.sv
`default_nettype none
// ============================================================================
// Module   : ring_decoder_checker
// Brief    : Receive-side one-hot ring decoder with legality/order checking,
//            HUNT/VERIFY/LOCK acquisition and a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module ring_decoder_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [WIDTH-1:0]     Ring_in,
  input  logic                 Ring_valid,
  input  logic                 Err_clr,
  output logic [IDX_W-1:0]     Index_out,
  output logic                 Index_valid,
  output logic                 Locked,
  output logic                 Code_err,
  output logic                 Seq_err,
  output logic [ERR_CNT_W-1:0] Err_count
);

  localparam int c_CNT_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_prev;
  logic [c_CNT_W-1:0] r_match_cnt;

  logic               w_legal;
  logic               w_in_order;
  logic [WIDTH-1:0]   w_expected;
  logic [IDX_W-1:0]   w_pos;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               w_code_err;
  logic               w_seq_err;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_legal    = (Ring_in != '0) && ((Ring_in & (Ring_in - WIDTH'(1))) == '0);
  assign w_expected = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
  assign w_in_order = (Ring_in == w_expected);
  assign w_cnt_inc  = r_match_cnt + c_CNT_W'(1);
  assign w_code_err = Ring_valid && !w_legal;
  assign w_seq_err  = Ring_valid && w_legal && !w_in_order && (r_state == S_LOCK);

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (Ring_in[i]) w_pos = IDX_W'(i);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_HUNT;
      r_prev      <= '0;
      r_match_cnt <= '0;
      Index_out   <= '0;
      Index_valid <= 1'b0;
      Code_err    <= 1'b0;
      Seq_err     <= 1'b0;
      Err_count   <= '0;
    end else begin
      Index_valid <= Ring_valid && w_legal;
      Code_err    <= w_code_err;
      Seq_err     <= w_seq_err;

      if (Err_clr) begin
        Err_count <= '0;
      end else if ((w_code_err || w_seq_err) && (Err_count != '1)) begin
        Err_count <= Err_count + ERR_CNT_W'(1);
      end

      if (Ring_valid) begin
        if (w_legal) begin
          Index_out <= w_pos;
          r_prev    <= Ring_in;
        end

        if (!w_legal) begin
          r_state     <= S_HUNT;
          r_match_cnt <= '0;
        end else begin
          case (r_state)
            S_HUNT: begin
              r_state     <= S_VERIFY;
              r_match_cnt <= c_CNT_W'(1);
            end
            S_VERIFY: begin
              if (w_in_order) begin
                r_match_cnt <= w_cnt_inc;
                if (w_cnt_inc == c_CNT_W'(LOCK_COUNT)) r_state <= S_LOCK;
              end else begin
                r_match_cnt <= c_CNT_W'(1);
              end
            end
            S_LOCK: begin
              if (!w_in_order) begin
                r_state     <= S_VERIFY;
                r_match_cnt <= c_CNT_W'(1);
              end
            end
            default: begin
              r_state     <= S_HUNT;
              r_match_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign Locked = (r_state == S_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_decoder_checker
// Brief    : Directed self-checking bench for ring_decoder_checker (4/3/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_decoder_checker;

  logic       r_clk;
  logic       r_rst_n;
  logic [3:0] r_ring;
  logic       r_valid;
  logic       r_clr;
  logic [1:0] w_index;
  logic       w_index_valid;
  logic       w_locked;
  logic       w_code_err;
  logic       w_seq_err;
  logic [7:0] w_err_count;

  int r_tests;
  int r_fails;

  ring_decoder_checker #(
    .WIDTH(4),
    .LOCK_COUNT(3),
    .ERR_CNT_W(8)
  ) u_dut (
    .Clock      (r_clk),
    .Reset_n    (r_rst_n),
    .Ring_in    (r_ring),
    .Ring_valid (r_valid),
    .Err_clr    (r_clr),
    .Index_out  (w_index),
    .Index_valid(w_index_valid),
    .Locked     (w_locked),
    .Code_err   (w_code_err),
    .Seq_err    (w_seq_err),
    .Err_count  (w_err_count)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_tests++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample on the falling edge, then sample outputs 1 after the rising edge.
  task automatic step(input logic [3:0] ring, input logic valid, input logic clr);
    @(negedge r_clk);
    r_ring  = ring;
    r_valid = valid;
    r_clr   = clr;
    @(posedge r_clk);
    #1;
    r_valid = 1'b0;
    r_clr   = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [1:0] idx, input logic iv,
                           input logic lk, input logic ce, input logic se, input logic [7:0] ec);
    check({tag, ".idx"},  {30'd0, w_index}, {30'd0, idx});
    check({tag, ".iv"},   {31'd0, w_index_valid}, {31'd0, iv});
    check({tag, ".lock"}, {31'd0, w_locked}, {31'd0, lk});
    check({tag, ".cerr"}, {31'd0, w_code_err}, {31'd0, ce});
    check({tag, ".serr"}, {31'd0, w_seq_err}, {31'd0, se});
    check({tag, ".ecnt"}, {24'd0, w_err_count}, {24'd0, ec});
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    r_rst_n = 1'b0;
    @(negedge r_clk);
    r_rst_n = 1'b1;
  endtask

  initial begin
    r_tests = 0;
    r_fails = 0;
    r_rst_n = 1'b0;
    r_ring  = 4'b0000;
    r_valid = 1'b0;
    r_clr   = 1'b0;
    #2;
    check_out("rst0", 2'd0, 0, 0, 0, 0, 8'd0);
    @(posedge r_clk);
    #1;
    check_out("rst1", 2'd0, 0, 0, 0, 0, 8'd0);
    @(negedge r_clk);
    r_rst_n = 1'b1;

    // 1: acquisition
    step(4'b0001, 1, 0); check_out("t1a", 2'd0, 1, 0, 0, 0, 8'd0);
    step(4'b0010, 1, 0); check_out("t1b", 2'd1, 1, 0, 0, 0, 8'd0);
    step(4'b0100, 1, 0); check_out("t1c", 2'd2, 1, 1, 0, 0, 8'd0);

    // 2: wrap-around stays locked
    step(4'b1000, 1, 0); check_out("t2a", 2'd3, 1, 1, 0, 0, 8'd0);
    step(4'b0001, 1, 0); check_out("t2b", 2'd0, 1, 1, 0, 0, 8'd0);

    // 3: illegal codes drop lock
    step(4'b0101, 1, 0); check_out("t3a", 2'd0, 0, 0, 1, 0, 8'd1);
    step(4'b0000, 0, 0); check_out("t3gap", 2'd0, 0, 0, 0, 0, 8'd1);
    step(4'b0010, 1, 0); check_out("t3b", 2'd1, 1, 0, 0, 0, 8'd1);
    step(4'b0100, 1, 0); check_out("t3c", 2'd2, 1, 0, 0, 0, 8'd1);
    step(4'b1000, 1, 0); check_out("t3d", 2'd3, 1, 1, 0, 0, 8'd1);
    step(4'b0000, 1, 0); check_out("t3e", 2'd3, 0, 0, 1, 0, 8'd2);

    // 4: out-of-order while locked
    step(4'b1000, 1, 0); check_out("t4a", 2'd3, 1, 0, 0, 0, 8'd2);
    step(4'b0001, 1, 0); check_out("t4b", 2'd0, 1, 0, 0, 0, 8'd2);
    step(4'b0010, 1, 0); check_out("t4c", 2'd1, 1, 1, 0, 0, 8'd2);
    step(4'b1000, 1, 0); check_out("t4d", 2'd3, 1, 0, 0, 1, 8'd3);
    step(4'b0001, 1, 0); check_out("t4e", 2'd0, 1, 0, 0, 0, 8'd3);
    step(4'b0010, 1, 0); check_out("t4f", 2'd1, 1, 1, 0, 0, 8'd3);

    // Legal but out of order in VERIFY restarts the count without an error.
    step(4'b0000, 1, 0); check_out("t4g", 2'd1, 0, 0, 1, 0, 8'd4);
    step(4'b0001, 1, 0); check_out("t4h", 2'd0, 1, 0, 0, 0, 8'd4);
    step(4'b0100, 1, 0); check_out("t4i", 2'd2, 1, 0, 0, 0, 8'd4);
    step(4'b1000, 1, 0); check_out("t4j", 2'd3, 1, 0, 0, 0, 8'd4);
    step(4'b0001, 1, 0); check_out("t4k", 2'd0, 1, 1, 0, 0, 8'd4);

    // 5: gaps with garbage on Ring_in while invalid
    do_reset();
    step(4'b0001, 1, 0); check_out("t5a", 2'd0, 1, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 0, 0); check_out("t5g1", 2'd0, 0, 0, 0, 0, 8'd0);
    end
    step(4'b0010, 1, 0); check_out("t5b", 2'd1, 1, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1000, 0, 0); check_out("t5g2", 2'd1, 0, 0, 0, 0, 8'd0);
    end
    step(4'b0100, 1, 0); check_out("t5c", 2'd2, 1, 1, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 0, 0); check_out("t5g3", 2'd2, 0, 1, 0, 0, 8'd0);
    end

    // 6: saturation, clear priority, async reset
    for (int i = 0; i < 260; i++) begin
      step(4'b1100, 1, 0);
      if (i == 253) check({"t6.254"}, {24'd0, w_err_count}, 32'd254);
    end
    check_out("t6sat", 2'd2, 0, 0, 1, 0, 8'd255);
    step(4'b0011, 1, 1); check_out("t6clr", 2'd2, 0, 0, 1, 0, 8'd0);
    step(4'b0001, 1, 0);
    step(4'b0010, 1, 0);
    step(4'b0100, 1, 0);
    step(4'b0000, 1, 0); check_out("t6e", 2'd2, 0, 0, 1, 0, 8'd1);
    step(4'b1000, 1, 0);
    step(4'b0001, 1, 0);
    step(4'b0010, 1, 0); check_out("t6l", 2'd1, 1, 1, 0, 0, 8'd1);
    #2;
    r_rst_n = 1'b0;
    #1;
    check_out("t6ar", 2'd0, 0, 0, 0, 0, 8'd0);
    r_rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

endmodule
`default_nettype wire
